// File: rtl/wb_regfile.sv
// Write-back register file: 2**AW x DW registers, two combinational read
// ports with write-first bypass, plus a retired-write counter and a
// last-write trace register for debug.
module wb_regfile #(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 3,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_rd_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic [AW-1:0] rs2_addr_i,
  output logic [DW-1:0] rs1_data_o,
  output logic [DW-1:0] rs2_data_o,
  output logic [15:0]   wr_count_o,
  output logic          last_wr_valid_o,
  output logic [AW-1:0] last_wr_rd_o,
  output logic [DW-1:0] last_wr_data_o
);

  localparam int unsigned NumRegs = 2 ** AW;
  localparam bit          HardR0  = (ZERO_R0 != 0);

  logic [DW-1:0] regs_q [NumRegs];
  logic [15:0]   wr_count_q, wr_count_d;
  logic          last_wr_valid_q;
  logic [AW-1:0] last_wr_rd_q;
  logic [DW-1:0] last_wr_data_q;
  logic          commit;

  // A write to R0 with a hardwired zero is dropped entirely: no storage,
  // counter or trace update, and no bypass.
  always_comb begin
    commit = wb_we_i;
    if (HardR0 && (wb_rd_i == '0)) begin
      commit = 1'b0;
    end
  end

  // Counter wraps naturally at 16 bits.
  always_comb begin
    wr_count_d = wr_count_q;
    if (commit) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  // Register storage; cleared asynchronously, one committed write per cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[wb_rd_i] <= wb_data_i;
    end
  end

  // Retired-write counter and last-write trace.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_count_q      <= '0;
      last_wr_valid_q <= 1'b0;
      last_wr_rd_q    <= '0;
      last_wr_data_q  <= '0;
    end else begin
      wr_count_q <= wr_count_d;
      if (commit) begin
        last_wr_valid_q <= 1'b1;
        last_wr_rd_q    <= wb_rd_i;
        last_wr_data_q  <= wb_data_i;
      end
    end
  end

  // Read port 1: hardwired zero, then same-cycle bypass, then storage.
  always_comb begin
    rs1_data_o = regs_q[rs1_addr_i];
    if (HardR0 && (rs1_addr_i == '0)) begin
      rs1_data_o = '0;
    end else if (commit && (wb_rd_i == rs1_addr_i)) begin
      rs1_data_o = wb_data_i;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rs2_data_o = regs_q[rs2_addr_i];
    if (HardR0 && (rs2_addr_i == '0)) begin
      rs2_data_o = '0;
    end else if (commit && (wb_rd_i == rs2_addr_i)) begin
      rs2_data_o = wb_data_i;
    end
  end

  assign wr_count_o      = wr_count_q;
  assign last_wr_valid_o = last_wr_valid_q;
  assign last_wr_rd_o    = last_wr_rd_q;
  assign last_wr_data_o  = last_wr_data_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: two instances (ZERO_R0=0 and ZERO_R0=1) driven with
// identical stimulus and compared against an array-based reference model.
module tb_wb_regfile;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        we;
  logic [2:0]  rd, a1, a2;
  logic [15:0] wd;

  logic [15:0] rs1 [2];
  logic [15:0] rs2 [2];
  logic [15:0] cnt [2];
  logic        lwv [2];
  logic [2:0]  lwr [2];
  logic [15:0] lwd [2];

  wb_regfile #(.DW(16), .AW(3), .ZERO_R0(0)) u_dut_plain (
    .clk_i(clk), .rst_i(rst), .wb_we_i(we), .wb_rd_i(rd), .wb_data_i(wd),
    .rs1_addr_i(a1), .rs2_addr_i(a2), .rs1_data_o(rs1[0]), .rs2_data_o(rs2[0]),
    .wr_count_o(cnt[0]), .last_wr_valid_o(lwv[0]), .last_wr_rd_o(lwr[0]),
    .last_wr_data_o(lwd[0])
  );

  wb_regfile #(.DW(16), .AW(3), .ZERO_R0(1)) u_dut_zero (
    .clk_i(clk), .rst_i(rst), .wb_we_i(we), .wb_rd_i(rd), .wb_data_i(wd),
    .rs1_addr_i(a1), .rs2_addr_i(a2), .rs1_data_o(rs1[1]), .rs2_data_o(rs2[1]),
    .wr_count_o(cnt[1]), .last_wr_valid_o(lwv[1]), .last_wr_rd_o(lwr[1]),
    .last_wr_data_o(lwd[1])
  );

  // Reference model, index 0 = plain R0, index 1 = hardwired-zero R0.
  logic [15:0] m_mem [2][8];
  int unsigned m_cnt [2];
  bit          m_v   [2];
  logic [2:0]  m_rd  [2];
  logic [15:0] m_dat [2];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_commit(input int i);
    return we && !(i == 1 && rd == 3'd0);
  endfunction

  function automatic logic [15:0] m_read(input int i, input logic [2:0] a);
    if (i == 1 && a == 3'd0) return 16'h0000;
    if (m_commit(i) && rd == a) return wd;
    return m_mem[i][a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 8; r++) m_mem[i][r] = 16'h0000;
      m_cnt[i] = 0;
      m_v[i]   = 1'b0;
      m_rd[i]  = 3'd0;
      m_dat[i] = 16'h0000;
    end
  endtask

  task automatic m_clock();
    for (int i = 0; i < 2; i++) begin
      if (m_commit(i)) begin
        m_mem[i][rd] = wd;
        m_cnt[i]     = (m_cnt[i] + 1) % 65536;
        m_v[i]       = 1'b1;
        m_rd[i]      = rd;
        m_dat[i]     = wd;
      end
    end
  endtask

  task automatic check_reads(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s rs1 dut%0d", tag, i), {16'h0, rs1[i]}, {16'h0, m_read(i, a1)});
      check_eq($sformatf("%s rs2 dut%0d", tag, i), {16'h0, rs2[i]}, {16'h0, m_read(i, a2)});
    end
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s wr_count dut%0d", tag, i), {16'h0, cnt[i]}, m_cnt[i]);
      check_eq($sformatf("%s last_valid dut%0d", tag, i), {31'h0, lwv[i]}, {31'h0, m_v[i]});
      check_eq($sformatf("%s last_rd dut%0d", tag, i), {29'h0, lwr[i]}, {29'h0, m_rd[i]});
      check_eq($sformatf("%s last_data dut%0d", tag, i), {16'h0, lwd[i]}, {16'h0, m_dat[i]});
    end
  endtask

  // Present one write-back beat on the falling edge, check reads before the
  // rising edge and committed state just after it.
  task automatic cycle(input bit w, input logic [2:0] d, input logic [15:0] v,
                       input logic [2:0] x, input logic [2:0] y, input bit chk,
                       input string tag);
    @(negedge clk);
    we = w; rd = d; wd = v; a1 = x; a2 = y;
    #2;
    if (chk) check_reads(tag);
    @(posedge clk);
    m_clock();
    #1;
    if (chk) check_state(tag);
  endtask

  initial begin
    int unsigned saved [2];
    we = 1'b0; rd = '0; wd = '0; a1 = '0; a2 = '0;
    m_reset();

    // Power-on reset.
    rst = 1'b1;
    #3;
    check_state("por");
    for (int r = 0; r < 8; r++) begin
      a1 = 3'(r); a2 = 3'(7 - r);
      #0.1;
      check_reads("por");
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed write/read: R3=BEEF then R5=1234.
    cycle(1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd0, 1'b1, "wr3");
    cycle(1'b1, 3'd5, 16'h1234, 3'd3, 3'd5, 1'b1, "wr5");
    cycle(1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 1'b1, "rd35");
    for (int i = 0; i < 2; i++) begin
      check_eq("dir rs1 r3", {16'h0, rs1[i]}, 32'hBEEF);
      check_eq("dir rs2 r5", {16'h0, rs2[i]}, 32'h1234);
      check_eq("dir wr_count", {16'h0, cnt[i]}, 32'd2);
      check_eq("dir last_rd", {29'h0, lwr[i]}, 32'd5);
      check_eq("dir last_data", {16'h0, lwd[i]}, 32'h1234);
    end

    // Bypass: R2 holds 0001, then write A5A5 with both ports on R2.
    cycle(1'b1, 3'd2, 16'h0001, 3'd2, 3'd2, 1'b1, "wr2");
    @(negedge clk);
    we = 1'b1; rd = 3'd2; wd = 16'hA5A5; a1 = 3'd2; a2 = 3'd2;
    #2;
    for (int i = 0; i < 2; i++) begin
      check_eq("byp rs1", {16'h0, rs1[i]}, 32'hA5A5);
      check_eq("byp rs2", {16'h0, rs2[i]}, 32'hA5A5);
    end
    @(posedge clk);
    m_clock();
    @(negedge clk);
    we = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) check_eq("byp stored", {16'h0, rs1[i]}, 32'hA5A5);

    // R0 write of FFFF: dropped on dut1, ordinary on dut0. Counts so far: 4.
    we = 1'b1; rd = 3'd0; wd = 16'hFFFF; a1 = 3'd0; a2 = 3'd0;
    #2;
    check_eq("r0 pre dut0", {16'h0, rs1[0]}, 32'hFFFF);
    check_eq("r0 pre dut1", {16'h0, rs1[1]}, 32'h0000);
    @(posedge clk);
    m_clock();
    @(negedge clk);
    we = 1'b0;
    #1;
    check_eq("r0 post dut0", {16'h0, rs1[0]}, 32'hFFFF);
    check_eq("r0 post dut1", {16'h0, rs1[1]}, 32'h0000);
    check_eq("r0 count dut0", {16'h0, cnt[0]}, 32'd5);
    check_eq("r0 count dut1", {16'h0, cnt[1]}, 32'd4);
    check_eq("r0 last_rd dut1", {29'h0, lwr[1]}, 32'd2);

    // Disabled write to R4.
    @(negedge clk);
    we = 1'b0; rd = 3'd4; wd = 16'h7777; a1 = 3'd4; a2 = 3'd4;
    #2;
    for (int i = 0; i < 2; i++) check_eq("dis pre", {16'h0, rs1[i]}, 32'h0000);
    @(posedge clk);
    m_clock();
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq("dis post", {16'h0, rs2[i]}, 32'h0000);
      check_eq("dis count", {16'h0, cnt[i]}, (i == 0) ? 32'd5 : 32'd4);
    end

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 3'($urandom), 16'($urandom),
            3'($urandom), 3'($urandom), 1'b1, "rnd");
    end

    // Mid-cycle reset with a write pending: write lost, state cleared at once.
    @(posedge clk);
    #2;
    we = 1'b1; rd = 3'd6; wd = 16'($urandom | 1);
    rst = 1'b1;
    m_reset();
    #0.5;
    check_state("rst");
    we = 1'b0;
    for (int r = 0; r < 8; r++) begin
      a1 = 3'(r); a2 = 3'(r);
      #0.2;
      check_reads("rst");
    end
    we = 1'b1;
    @(posedge clk);
    #1;
    check_state("rst held");
    @(negedge clk);
    rst = 1'b0;
    we = 1'b0;
    cycle(1'b0, 3'd6, 16'h0000, 3'd6, 3'd1, 1'b1, "post rst");

    // Counter wrap: 65536 commits on both instances return the count.
    cycle(1'b1, 3'd1, 16'h1111, 3'd1, 3'd0, 1'b1, "pre wrap");
    for (int i = 0; i < 2; i++) saved[i] = m_cnt[i];
    for (int n = 0; n < 65536; n++) begin
      cycle(1'b1, 3'($urandom_range(1, 7)), 16'($urandom), 3'd0, 3'd0, 1'b0, "wrap");
    end
    cycle(1'b0, 3'd0, 16'h0000, 3'($urandom), 3'($urandom), 1'b1, "wrap end");
    for (int i = 0; i < 2; i++) begin
      check_eq("wrap count", {16'h0, cnt[i]}, saved[i]);
      check_eq("wrap valid", {31'h0, lwv[i]}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back end of the 16-bit pipeline: the general-purpose register file that consumes the write port driven by the MEM/WB pipeline register. It holds eight 16-bit registers and provides two combinational read ports to decode. It commits one write per cycle from the write-back stage and bypasses a same-cycle write to the read ports. It also keeps a retired-write counter and a last-write trace register for debug.

## Interface
Parameters:
- DW, 16, data width of each register
- AW, 3, register address width (2**AW registers)
- ZERO_R0, 1, when 1 register 0 reads as 0 and ignores writes

Ports:
- clk  in  1  clock; register writes on rising edge
- rst  in  1  reset, asynchronous, active-high
- wb_we  in  1  write enable from MEM/WB RegWrite output
- wb_rd  in  AW  destination register from MEM/WB
- wb_data  in  DW  write data from MEM/WB
- rs1_addr  in  AW  read port 1 address
- rs2_addr  in  AW  read port 2 address
- rs1_data  out  DW  read port 1 data (combinational)
- rs2_data  out  DW  read port 2 data (combinational)
- wr_count  out  16  number of committed writes, wraps
- last_wr_valid  out  1  at least one write committed since reset
- last_wr_rd  out  AW  destination of most recent committed write
- last_wr_data  out  DW  data of most recent committed write

## Operation
- Storage: 2**AW registers of DW bits, all cleared to 0 by rst.
- Commit condition: wb_we=1 and not (ZERO_R0=1 and wb_rd=0). A write with wb_we=1 to R0 under ZERO_R0=1 is dropped: no storage update, no counter increment, no trace update.
- On a committed write at rising clk: reg[wb_rd] <= wb_data; wr_count <= wr_count+1 (mod 2**16, 0xFFFF -> 0x0000); last_wr_valid <= 1; last_wr_rd <= wb_rd; last_wr_data <= wb_data.
- Read ports, each independent and combinational:
  - If ZERO_R0=1 and addr=0: output 0.
  - Else if commit condition holds and wb_rd=addr: output wb_data (bypass, write-first).
  - Else: output reg[addr].
- Both ports addressing the same register return identical data.
- wb_we=0: wb_rd and wb_data are don't-care; no state change.
- ZERO_R0=0: R0 is an ordinary register. It is writable, bypassed and counted.

## Timing
- Reset: all registers 0, rs1_data/rs2_data reflect 0 (unless bypass active), wr_count=0, last_wr_valid=0, last_wr_rd=0, last_wr_data=0; applies immediately on rst assertion, independent of clk.
- rst asserted mid-cycle with wb_we=1: write is lost; state stays at reset values until the first rising clk after rst deasserts.
- MEM/WB launches on falling clk; this block captures on the following rising clk, giving a half-cycle path. Write latency: visible in storage 1 rising edge after presentation; visible at read ports in the same cycle via bypass.
- Read latency: 0 cycles (combinational from rs*_addr, wb_* and storage).
- MEM/WB flush drives wb_we=0; this block needs no flush input.
- Back-to-back writes to the same register: the last one wins; wr_count increments once per cycle.

## Test plan
- Reset: assert rst mid-simulation after writes -> all reads of R0..R7 return 0x0000, wr_count=0, last_wr_valid=0, without a clock edge.
- Write/read: write R3=0xBEEF, then R5=0x1234 on consecutive edges -> rs1_addr=3 gives 0xBEEF, rs2_addr=5 gives 0x1234, wr_count=2, last_wr_rd=5, last_wr_data=0x1234.
- Bypass: R2 holds 0x0001; present wb_we=1, wb_rd=2, wb_data=0xA5A5 with rs1_addr=rs2_addr=2 -> both outputs 0xA5A5 before the edge, and storage holds 0xA5A5 after it.
- R0: ZERO_R0=1, write R0=0xFFFF -> rs1_data(addr 0)=0 before and after the edge, wr_count unchanged. Repeat with ZERO_R0=0 -> reads 0xFFFF, count +1.
- Disabled write: wb_we=0 with wb_rd=4, wb_data=0x7777 -> R4 unchanged, no bypass, wr_count unchanged.
- Counter wrap: 65536 committed writes -> wr_count returns to 0x0000, last_wr_valid stays 1.
